// File: rtl/deslocador_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble): one adjust cycle and one shift cycle per input bit,
// so Valido arrives 2*LARGURA cycles after a start. Iniciar is honoured only while Pronto is high; it is never queued.
module deslocador_bcd_seq #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Iniciar,
  input  logic [LARGURA-1:0]     Entrada,
  output logic                   Pronto,
  output logic                   Valido,
  output logic [4*DIGITOS-1:0]   Saida,
  output logic                   Estouro
);

  localparam int BW = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {OCIOSO, AJUSTA, DESLOCA, FIM} estado_t;

  estado_t            estado_q;
  logic [LARGURA-1:0] bin_q;
  logic [LARGURA-1:0] bin_d;
  logic [BW-1:0]      bcd_q;
  logic [BW-1:0]      bcd_aj_d;
  logic [BW-1:0]      bcd_d;
  logic [CW-1:0]      cnt_q;
  logic               ovf_q;
  logic               ovf_d;
  logic [BW-1:0]      saida_q;
  logic               estouro_q;

  // Digits never exceed 9, so the +3 on a digit of 5..9 always fits in 4 bits.
  always_comb begin
    bcd_aj_d = bcd_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_aj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit would start digit DIGITOS; losing it means overflow.
  always_comb begin
    {bcd_d, bin_d} = {bcd_q[BW-2:0], bin_q, 1'b0};
    ovf_d          = ovf_q | bcd_q[BW-1];
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q  <= OCIOSO;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      saida_q   <= '0;
      estouro_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (Iniciar) begin
            bin_q    <= Entrada;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= CW'(LARGURA);
            estado_q <= AJUSTA;
          end
        end
        AJUSTA: begin
          bcd_q    <= bcd_aj_d;
          estado_q <= DESLOCA;
        end
        DESLOCA: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            saida_q   <= bcd_d;
            estouro_q <= ovf_d;
            estado_q  <= FIM;
          end else begin
            estado_q <= AJUSTA;
          end
        end
        FIM: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign Pronto  = (estado_q == OCIOSO);
  assign Valido  = (estado_q == FIM);
  assign Saida   = saida_q;
  assign Estouro = estouro_q;

endmodule

// File: tb/tb_deslocador_bcd_seq.sv
// Bench for deslocador_bcd_seq: three instances (8b/3 digits, 8b/2 digits, 16b/5 digits) driven from a vector table.
`timescale 1ns/1ps
module tb_deslocador_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        ini [3];
  logic [15:0] ent;

  logic        pronto [3];
  logic        valido [3];
  logic        est    [3];
  logic [11:0] s0;
  logic [7:0]  s1;
  logic [19:0] s2;

  int nvec;
  int nfail;

  deslocador_bcd_seq #(.LARGURA(8), .DIGITOS(3)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .Iniciar(ini[0]), .Entrada(ent[7:0]),
    .Pronto(pronto[0]), .Valido(valido[0]), .Saida(s0), .Estouro(est[0]));
  deslocador_bcd_seq #(.LARGURA(8), .DIGITOS(2)) dut1 (
    .Clock(clk), .Reset_n(rst_n), .Iniciar(ini[1]), .Entrada(ent[7:0]),
    .Pronto(pronto[1]), .Valido(valido[1]), .Saida(s1), .Estouro(est[1]));
  deslocador_bcd_seq #(.LARGURA(16), .DIGITOS(5)) dut2 (
    .Clock(clk), .Reset_n(rst_n), .Iniciar(ini[2]), .Entrada(ent),
    .Pronto(pronto[2]), .Valido(valido[2]), .Saida(s2), .Estouro(est[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [15:0] val;
    logic [19:0] exp_s;
    logic        exp_e;
  } vec_t;

  function automatic logic [19:0] saida_of(input int d);
    case (d)
      0:       return {8'h00, s0};
      1:       return {12'h000, s1};
      default: return s2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller positions us away from the rising edge; the start is taken on the next one.
  task automatic launch(input int d, input logic [15:0] v);
    ini[d] = 1'b1;
    ent    = v;
    @(posedge clk); #1;
    check("accept_pronto_low", {31'b0, pronto[d]}, 32'd0);
    ini[d] = 1'b0;
    ent    = ~v;
  endtask

  // Counts edges from the accepting edge until Valido, then checks result and the return to idle.
  task automatic finish(input int d, input logic [19:0] exp_s, input logic exp_e, input string name);
    int lat;
    int busy_bad;
    lat      = 0;
    busy_bad = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (valido[d]) begin
        lat = c;
        break;
      end
      if (pronto[d]) busy_bad++;
    end
    check({name, "_latency"}, lat, (d == 2) ? 32 : 16);
    check({name, "_pronto_busy"}, busy_bad, 0);
    check({name, "_saida"}, {12'b0, saida_of(d)}, {12'b0, exp_s});
    check({name, "_estouro"}, {31'b0, est[d]}, {31'b0, exp_e});
    @(posedge clk); #1;
    check({name, "_idle_after"}, {30'b0, pronto[d], valido[d]}, 32'd2);
  endtask

  vec_t tab [12];

  initial begin
    nvec  = 0;
    nfail = 0;
    tab[0]  = '{0, 16'd0,     20'h00000, 1'b0};
    tab[1]  = '{0, 16'd255,   20'h00255, 1'b0};
    tab[2]  = '{0, 16'd99,    20'h00099, 1'b0};
    tab[3]  = '{0, 16'd128,   20'h00128, 1'b0};
    tab[4]  = '{0, 16'd1,     20'h00001, 1'b0};
    tab[5]  = '{1, 16'd255,   20'h00055, 1'b1};
    tab[6]  = '{1, 16'd42,    20'h00042, 1'b0};
    tab[7]  = '{1, 16'd100,   20'h00000, 1'b1};
    tab[8]  = '{1, 16'd99,    20'h00099, 1'b0};
    tab[9]  = '{2, 16'd65535, 20'h65535, 1'b0};
    tab[10] = '{2, 16'd10000, 20'h10000, 1'b0};
    tab[11] = '{2, 16'd0,     20'h00000, 1'b0};

    rst_n = 1'b0;
    ent   = 16'h0;
    for (int i = 0; i < 3; i++) ini[i] = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      check("reset_pronto_valido", {30'b0, pronto[i], valido[i]}, 32'd2);
      check("reset_saida_estouro", {11'b0, saida_of(i), est[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[k]) begin
      @(negedge clk);
      launch(tab[k].d, tab[k].val);
      finish(tab[k].d, tab[k].exp_s, tab[k].exp_e, $sformatf("vec%0d", k));
      // Outputs must hold until the next completion.
      repeat (3) @(posedge clk);
      #1;
      check("hold_saida", {12'b0, saida_of(tab[k].d)}, {12'b0, tab[k].exp_s});
    end

    // Iniciar held high across a whole conversion: no request taken while busy.
    @(negedge clk);
    ini[0] = 1'b1;
    ent    = 16'd200;
    @(posedge clk); #1;
    check("held_accept", {31'b0, pronto[0]}, 32'd0);
    ent = 16'd7;
    finish(0, 20'h00200, 1'b0, "held_first");
    @(posedge clk); #1;
    check("held_second_accept", {31'b0, pronto[0]}, 32'd0);
    ini[0] = 1'b0;
    finish(0, 20'h00007, 1'b0, "held_second");

    // Reset five cycles into a conversion of 123.
    @(negedge clk);
    launch(0, 16'd123);
    repeat (4) @(posedge clk);
    #1;
    check("midconv_busy", {31'b0, pronto[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_saida", {20'b0, s0}, 32'd0);
    check("async_rst_flags", {29'b0, pronto[0], valido[0], est[0]}, 32'd4);
    repeat (2) @(negedge clk);
    check("rst_hold_valido", {31'b0, valido[0]}, 32'd0);
    rst_n = 1'b1;
    launch(0, 16'd123);
    finish(0, 20'h00123, 1'b0, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/deslocador_bcd_seq.md
DESLOCADOR_BCD_SEQ -- requirements
Module: deslocador_bcd_seq

Interface
REQ-001 SHALL have parameter LARGURA, default 8: binary input width; legal values are 1 or more.
REQ-002 SHALL have parameter DIGITOS, default 3: number of 4-bit BCD output digits; legal values are 1 or more.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Iniciar, input, 1 bit: start request, sampled at the rising edge.
REQ-006 SHALL have port Entrada, input, LARGURA bits: unsigned binary value, captured only when a start is accepted.
REQ-007 SHALL have port Pronto, output, 1 bit: high when idle and able to accept Iniciar.
REQ-008 SHALL have port Valido, output, 1 bit: single-cycle completion strobe.
REQ-009 SHALL have port Saida, output, 4*DIGITOS bits: BCD result; digit 0 occupies Saida[3:0].
REQ-010 SHALL have port Estouro, output, 1 bit: result did not fit in DIGITOS digits.

Function
REQ-011 SHALL implement a sequential shift-and-add-3 (double dabble) conversion, one binary bit per shift step.
REQ-012 SHALL use a four-state FSM: OCIOSO, AJUSTA, DESLOCA, FIM.
REQ-013 Pronto SHALL be 1 only in OCIOSO and Valido SHALL be 1 only in FIM; both are decoded from the state register.
REQ-014 In OCIOSO with Iniciar=1 at an edge, the block SHALL load Entrada into the binary shift register, clear the BCD work register and the overflow flag, set the bit counter to LARGURA, and go to AJUSTA.
REQ-015 In OCIOSO with Iniciar=0, the block SHALL hold all registers.
REQ-016 Iniciar SHALL be ignored in every state except OCIOSO; there is no queueing of requests.
REQ-017 In AJUSTA, for one cycle, every BCD work digit with value 5 or more SHALL have 3 added (4-bit result, no carry to the next digit); the FSM then goes to DESLOCA.
REQ-018 In DESLOCA, for one cycle, {BCD work, binary reg} SHALL shift left one bit.
REQ-019 In that shift, the binary MSB SHALL enter BCD bit 0 and 0 SHALL enter binary bit 0.
REQ-020 In that shift, a 1 leaving the BCD MSB SHALL set the sticky overflow flag, and the counter SHALL decrement.
REQ-021 In DESLOCA, if the decremented counter equals 0, the FSM SHALL go to FIM and the edge SHALL load Saida from the shifted BCD work value and Estouro from the final overflow flag; otherwise the FSM SHALL go to AJUSTA.
REQ-022 FIM SHALL last exactly one cycle and then return to OCIOSO; a new start is accepted at the earliest on the edge after FIM.
REQ-023 Latency SHALL be fixed: Valido is high in the cycle beginning 2*LARGURA edges after the accepting edge, independent of data.
REQ-024 Saida and Estouro SHALL hold their values from the last completion until the next completion or reset.
REQ-025 On overflow, Saida SHALL equal Entrada mod 10^DIGITOS in BCD and Estouro SHALL be 1.
REQ-026 When the result fits, Estouro SHALL be 0.
REQ-027 Changes on Entrada after the accepting edge SHALL NOT affect the conversion in progress.
REQ-028 The bit counter SHALL be sized to hold the value LARGURA, and no register SHALL wrap silently.

Reset
REQ-029 Reset_n=0 SHALL immediately, without a clock, force state OCIOSO and clear the binary register, BCD work register, counter, overflow flag, Saida and Estouro to 0.
REQ-030 During and after reset: Pronto=1, Valido=0.
REQ-031 Reset asserted mid-conversion SHALL abort it with no Valido pulse; Saida returns to 0.
REQ-032 The first start SHALL be accepted on the first rising edge after Reset_n returns to 1 with Iniciar=1.

Verification
REQ-033 LARGURA=8, DIGITOS=3, Entrada=0, Iniciar pulse -> Valido high exactly 16 cycles after the accepting edge, Saida=12'h000, Estouro=0, Pronto=1 on the following cycle.
REQ-034 LARGURA=8, DIGITOS=3, Entrada=255 -> Saida=12'h255, Estouro=0; then Entrada=99 -> Saida=12'h099.
REQ-035 LARGURA=8, DIGITOS=2, Entrada=255 -> Saida=8'h55, Estouro=1; then Entrada=42 -> Saida=8'h42, Estouro=0.
REQ-036 Iniciar held high continuously, with Entrada changed to 7 after the accepting edge of 200 -> first result 12'h200; the next start is accepted on the edge after FIM and yields 12'h007; no start is taken during AJUSTA/DESLOCA/FIM.
REQ-037 Reset_n pulsed low 5 cycles into a conversion of 123 -> outputs cleared asynchronously, no Valido pulse, Pronto=1; a restart yields 12'h123.
REQ-038 LARGURA=16, DIGITOS=5, Entrada=65535 -> Saida=20'h65535, Estouro=0, Valido exactly 32 cycles after the accepting edge.
